// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the execute-stage branch redirect unit.
// Branch condition codes, FSM encoding and default widths.
package branch_redirect_unit_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;

endpackage

// File: rtl/branch_compare.sv
// Conditional-branch comparator for RV32I funct3 codes.
// Purely combinational; reserved codes are never taken.
module branch_compare
  import branch_redirect_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_val == rs2_val);
  assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
  assign lt_u = (rs1_val < rs2_val);

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Resolves branches/jumps in EX, issues redirect and flush pulses,
// masks wrong-path instructions during a shadow window, keeps stats.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  output logic             redirect,
  output logic [XLEN-1:0]  target,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0]       SH_LOAD = 3'(SHADOW_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state;
  logic [2:0]      sh_cnt;
  logic            br_taken;
  logic            one_kind;
  logic            eval;
  logic            taken;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] tgt;
  logic            aligned;
  logic            do_redir;
  logic            do_mis;

  branch_compare #(
    .XLEN(XLEN)
  ) u_cmp (
    .funct3 (funct3),
    .rs1_val(rs1_val),
    .rs2_val(rs2_val),
    .taken  (br_taken)
  );

  // Conflicting type flags make the instruction a non-transfer.
  assign one_kind = $onehot({is_branch, is_jal, is_jalr});
  assign eval     = ex_valid & ~stall & one_kind
                  & (state == ST_IDLE);
  assign taken    = is_jal | is_jalr | (is_branch & br_taken);

  assign base     = is_jalr ? rs1_val : pc;
  assign sum      = base + imm;
  assign tgt      = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign aligned  = (tgt[1:0] == 2'b00);

  assign do_redir = eval & taken & aligned;
  assign do_mis   = eval & taken & ~aligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sh_cnt      <= 3'd0;
      redirect    <= 1'b0;
      target      <= '0;
      flush_if_id <= 1'b0;
      flush_id_ex <= 1'b0;
      misalign    <= 1'b0;
      branch_cnt  <= '0;
      taken_cnt   <= '0;
    end else begin
      redirect    <= do_redir;
      flush_if_id <= do_redir;
      flush_id_ex <= do_redir;
      misalign    <= do_mis;

      if (eval && taken) begin
        target <= tgt;
      end

      if (eval && (branch_cnt != CNT_MAX)) begin
        branch_cnt <= branch_cnt + 1'b1;
      end
      if (do_redir && (taken_cnt != CNT_MAX)) begin
        taken_cnt <= taken_cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (do_redir) begin
            state  <= ST_SHADOW;
            sh_cnt <= SH_LOAD;
          end
        end
        ST_SHADOW: begin
          if (!stall) begin
            if (sh_cnt == 3'd1) begin
              state  <= ST_IDLE;
              sh_cnt <= 3'd0;
            end else begin
              sh_cnt <= sh_cnt - 3'd1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          sh_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed scoreboard bench for branch_redirect_unit.
// Counters are 2 bits wide so saturation is reachable.
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        stall;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        redirect;
  logic [31:0] target;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign;
  logic [1:0]  branch_cnt;
  logic [1:0]  taken_cnt;

  branch_redirect_unit #(
    .XLEN(32),
    .SHADOW_CYCLES(2),
    .CNT_W(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .stall      (stall),
    .is_branch  (is_branch),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .funct3     (funct3),
    .pc         (pc),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .redirect   (redirect),
    .target     (target),
    .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex),
    .misalign   (misalign),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        red;
    logic [31:0] tgt;
    logic        f1;
    logic        f2;
    logic        mis;
    logic [1:0]  bc;
    logic [1:0]  tc;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    errors = 0;
  int    checks = 0;

  // reference model state
  bit          m_shadow;
  int          m_sh;
  logic [31:0] m_tgt;
  int          m_bc;
  int          m_tc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(logic [2:0] f, logic [31:0] a,
                              logic [31:0] b);
    bit r;
    case (f[2:1])
      2'b00:   r = (a == b);
      2'b10:   r = ($signed(a) < $signed(b));
      2'b11:   r = (a < b);
      default: return 1'b0;
    endcase
    return r ^ f[0];
  endfunction

  task automatic compare_out();
    exp_t  e;
    string t;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sbq.pop_front();
    t = tagq.pop_front();
    chk({t, ".redirect"}, 32'(redirect), 32'(e.red));
    chk({t, ".target"}, target, e.tgt);
    chk({t, ".flush_if_id"}, 32'(flush_if_id), 32'(e.f1));
    chk({t, ".flush_id_ex"}, 32'(flush_id_ex), 32'(e.f2));
    chk({t, ".misalign"}, 32'(misalign), 32'(e.mis));
    chk({t, ".branch_cnt"}, 32'(branch_cnt), 32'(e.bc));
    chk({t, ".taken_cnt"}, 32'(taken_cnt), 32'(e.tc));
  endtask

  task automatic do_reset(string tag);
    exp_t e;
    reset = 1'b1;
    m_shadow = 1'b0;
    m_sh = 0;
    m_tgt = 32'h0;
    m_bc = 0;
    m_tc = 0;
    e = '0;
    sbq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_out();
  endtask

  // kind = {branch, jal, jalr}
  task automatic step(string tag, bit vld, bit stl, bit [2:0] kind,
                      logic [2:0] f3, logic [31:0] p,
                      logic [31:0] im, logic [31:0] a,
                      logic [31:0] b);
    exp_t        e;
    int          nk;
    bit          ev;
    bit          tk;
    logic [31:0] t;
    ex_valid  = vld;
    stall     = stl;
    is_branch = kind[2];
    is_jal    = kind[1];
    is_jalr   = kind[0];
    funct3    = f3;
    pc        = p;
    imm       = im;
    rs1_val   = a;
    rs2_val   = b;

    nk = int'(kind[2]) + int'(kind[1]) + int'(kind[0]);
    ev = vld && !stl && !m_shadow && (nk == 1);
    tk = kind[1] || kind[0] || (kind[2] && cond(f3, a, b));
    t  = kind[0] ? ((a + im) & 32'hFFFF_FFFE) : (p + im);
    e = '0;
    e.red = ev && tk && (t[1:0] == 2'b00);
    e.mis = ev && tk && (t[1:0] != 2'b00);
    e.f1  = e.red;
    e.f2  = e.red;
    if (ev && tk) m_tgt = t;
    e.tgt = m_tgt;
    if (ev && m_bc < 3) m_bc++;
    if (e.red && m_tc < 3) m_tc++;
    e.bc = 2'(m_bc);
    e.tc = 2'(m_tc);
    if (!m_shadow) begin
      if (e.red) begin
        m_shadow = 1'b1;
        m_sh = 2;
      end
    end else if (!stl) begin
      m_sh--;
      if (m_sh == 0) m_shadow = 1'b0;
    end
    sbq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) begin
      step(tag, 0, 0, 3'b000, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; stall = 0;
    is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 0; pc = 0; imm = 0; rs1_val = 0; rs2_val = 0;
    #1;

    do_reset("reset0");

    // BEQ taken
    step("beq", 1, 0, 3'b100, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
    chk("beq_target_const", target, 32'h120);
    chk("beq_redirect_const", 32'(redirect), 32'd1);
    idle("beq_after", 1);
    chk("beq_pulse_end", 32'(redirect), 32'd0);
    chk("beq_taken_cnt", 32'(taken_cnt), 32'd1);
    idle("beq_after", 1);

    // signed vs unsigned less-than
    do_reset("reset1");
    step("blt", 1, 0, 3'b100, 3'b100, 32'h300, 32'h40,
         32'hFFFF_FFFF, 32'd1);
    chk("blt_redirect_const", 32'(redirect), 32'd1);
    idle("blt_after", 2);
    step("bltu", 1, 0, 3'b100, 3'b110, 32'h300, 32'h40,
         32'hFFFF_FFFF, 32'd1);
    chk("bltu_redirect_const", 32'(redirect), 32'd0);
    chk("bltu_branch_cnt", 32'(branch_cnt), 32'd2);
    step("bgeu", 1, 0, 3'b100, 3'b111, 32'h300, 32'h44,
         32'hFFFF_FFFF, 32'd1);
    idle("bgeu_after", 2);
    step("bge_nt", 1, 0, 3'b100, 3'b101, 32'h300, 32'h8,
         32'hFFFF_FFFF, 32'd1);

    // JALR misaligned, then aligned with bit 0 cleared
    do_reset("reset2");
    step("jalr_mis", 1, 0, 3'b001, 3'b000, 32'h0, 32'h0, 32'h203, 32'h0);
    chk("jalr_mis_target", target, 32'h202);
    chk("jalr_mis_flag", 32'(misalign), 32'd1);
    chk("jalr_mis_tc", 32'(taken_cnt), 32'd0);
    step("jalr_ok", 1, 0, 3'b001, 3'b000, 32'h0, 32'h3, 32'h2001, 32'h0);
    chk("jalr_ok_target", target, 32'h2004);
    chk("jalr_ok_redirect", 32'(redirect), 32'd1);
    idle("jalr_after", 2);

    // shadow masking
    do_reset("reset3");
    step("bne", 1, 0, 3'b100, 3'b001, 32'h400, 32'h8, 32'd1, 32'd2);
    step("jal_sh1", 1, 0, 3'b010, 3'b000, 32'h500, 32'h10, 32'h0, 32'h0);
    chk("jal_sh1_ignored", 32'(redirect), 32'd0);
    step("jal_sh2", 1, 0, 3'b010, 3'b000, 32'h500, 32'h10, 32'h0, 32'h0);
    step("jal_idle", 1, 0, 3'b010, 3'b000, 32'h500, 32'h10, 32'h0, 32'h0);
    chk("jal_idle_target", target, 32'h510);
    chk("jal_idle_redirect", 32'(redirect), 32'd1);
    idle("jal_after", 2);
    step("f3_010", 1, 0, 3'b100, 3'b010, 32'h40, 32'h8, 32'd3, 32'd3);
    step("multi", 1, 0, 3'b110, 3'b000, 32'h40, 32'h8, 32'd3, 32'd3);
    chk("multi_bc", 32'(branch_cnt), 32'd3);

    // wrap-around target
    do_reset("reset4");
    step("wrap", 1, 0, 3'b010, 3'b000, 32'hFFFF_FFF0, 32'h20,
         32'h0, 32'h0);
    chk("wrap_target", target, 32'h10);
    idle("wrap_after", 2);

    // stall: blocks evaluation in IDLE, freezes shadow
    step("stall_idle", 1, 1, 3'b010, 3'b000, 32'h600, 32'h4,
         32'h0, 32'h0);
    step("stall_jal", 1, 0, 3'b010, 3'b000, 32'h600, 32'h4, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("stall_sh", 1, 1, 3'b010, 3'b000, 32'h700, 32'h4,
           32'h0, 32'h0);
    end
    chk("stall_pulse_one", 32'(redirect), 32'd0);
    step("stall_sh_a", 1, 0, 3'b010, 3'b000, 32'h700, 32'h4,
         32'h0, 32'h0);
    step("stall_sh_b", 1, 0, 3'b010, 3'b000, 32'h700, 32'h4,
         32'h0, 32'h0);
    step("stall_exit", 1, 0, 3'b010, 3'b000, 32'h800, 32'h4,
         32'h0, 32'h0);
    chk("stall_exit_target", target, 32'h804);
    step("stall_pulse", 1, 1, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    idle("stall_after", 1);

    // saturation then reset mid-shadow
    do_reset("reset5");
    for (int i = 0; i < 4; i++) begin
      step("sat_jal", 1, 0, 3'b010, 3'b000, 32'h900, 32'h8,
           32'h0, 32'h0);
      idle("sat_gap", 2);
    end
    chk("sat_taken_cnt", 32'(taken_cnt), 32'd3);
    chk("sat_branch_cnt", 32'(branch_cnt), 32'd3);
    step("pre_rst", 1, 0, 3'b010, 3'b000, 32'hA00, 32'h8, 32'h0, 32'h0);
    do_reset("reset_mid");
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    step("post_rst", 1, 0, 3'b100, 3'b000, 32'hB00, 32'h4, 32'd7, 32'd7);
    chk("post_rst_redirect", 32'(redirect), 32'd1);
    chk("post_rst_target", target, 32'hB04);
    idle("end", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
